// File: rtl/olivia_exec_checker.sv
// Execution checker beside the Olivia LEGv8 core: decodes each retiring instruction,
// recomputes the expected ALU/branch result, counts classes and logs mismatches in a trace FIFO.
module olivia_exec_checker #(
    parameter int DATA_W         = 64,
    parameter int PC_W           = 64,
    parameter int CNT_W          = 16,
    parameter int TRACE_DEPTH    = 8,
    parameter int HALT_ON_ERR    = 0,
    parameter int UNKNOWN_IS_ERR = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clear,
    input  logic                valid,
    input  logic [31:0]         instr,
    input  logic [PC_W-1:0]     pc,
    input  logic [DATA_W-1:0]   rd1,
    input  logic [DATA_W-1:0]   rd2,
    input  logic [DATA_W-1:0]   imm,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                zero_flag,
    output logic [10*CNT_W-1:0] cnt_class,
    output logic [CNT_W-1:0]    err_count,
    output logic                err_flag,
    output logic [PC_W-1:0]     first_err_pc,
    output logic                halted,
    output logic                trace_valid,
    output logic [PC_W-1:0]     trace_pc,
    output logic [3:0]          trace_class,
    output logic [DATA_W-1:0]   trace_expected,
    output logic [DATA_W-1:0]   trace_actual,
    input  logic                trace_pop,
    output logic                trace_overflow
);

    localparam int NUM_CLASSES = 10;
    localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [OCC_W-1:0] OCC_ONE = {{(OCC_W-1){1'b0}}, 1'b1};
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(TRACE_DEPTH);

    typedef enum logic [3:0] {
        CLS_ADD = 4'd0, CLS_SUB = 4'd1, CLS_AND = 4'd2, CLS_ORR = 4'd3, CLS_LDUR = 4'd4,
        CLS_STUR = 4'd5, CLS_CBZ = 4'd6, CLS_B = 4'd7, CLS_NOP = 4'd8, CLS_UNKNOWN = 4'd9
    } class_e;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

    function automatic class_e decode_class(input logic [31:0] ins);
        class_e cls;
        if (ins == 32'd0) begin
            cls = CLS_NOP;
        end else begin
            case (ins[31:21])
                11'b10001011000: cls = CLS_ADD;
                11'b11001011000: cls = CLS_SUB;
                11'b10001010000: cls = CLS_AND;
                11'b10101010000: cls = CLS_ORR;
                11'b11111000010: cls = CLS_LDUR;
                11'b11111000000: cls = CLS_STUR;
                11'b10110100000: cls = CLS_CBZ;
                11'b00010100000: cls = CLS_B;
                default:         cls = CLS_UNKNOWN;
            endcase
        end
        return cls;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    class_e              cls_s;
    state_e              state_r;
    logic [DATA_W-1:0]   expected_s, actual_s;
    logic                mismatch_s, accept_s, log_s, pop_s, full_s, push_s, drop_s;
    logic [CNT_W-1:0]    cnt_r [NUM_CLASSES];
    logic [PTR_W-1:0]    rd_ptr_r, wr_ptr_r, rd_ptr_s;
    logic [OCC_W-1:0]    occ_r, occ_s;
    logic [PC_W-1:0]     mem_pc_r  [TRACE_DEPTH];
    logic [3:0]          mem_cls_r [TRACE_DEPTH];
    logic [DATA_W-1:0]   mem_exp_r [TRACE_DEPTH];
    logic [DATA_W-1:0]   mem_act_r [TRACE_DEPTH];
    logic [PC_W-1:0]     head_pc_s;
    logic [3:0]          head_cls_s;
    logic [DATA_W-1:0]   head_exp_s, head_act_s;

    // Decode the retiring instruction and recompute what the core should have produced.
    always_comb begin
        cls_s      = decode_class(instr);
        expected_s = '0;
        actual_s   = alu_result;
        mismatch_s = 1'b0;
        case (cls_s)
            CLS_ADD:            expected_s = rd1 + rd2;
            CLS_SUB:            expected_s = rd1 - rd2;
            CLS_AND:            expected_s = rd1 & rd2;
            CLS_ORR:            expected_s = rd1 | rd2;
            CLS_LDUR, CLS_STUR: expected_s = rd1 + imm;
            CLS_CBZ: begin
                expected_s = {{(DATA_W-1){1'b0}}, (rd2 == '0)};
                actual_s   = {{(DATA_W-1){1'b0}}, zero_flag};
            end
            CLS_UNKNOWN:        actual_s = DATA_W'(instr);
            default:            actual_s = '0;
        endcase
        case (cls_s)
            CLS_B, CLS_NOP: mismatch_s = 1'b0;
            CLS_UNKNOWN:    mismatch_s = (UNKNOWN_IS_ERR != 0);
            default:        mismatch_s = (actual_s != expected_s);
        endcase
    end

    assign accept_s = valid && (state_r == ST_RUN);
    assign log_s    = accept_s && mismatch_s;
    assign pop_s    = trace_pop && (occ_r != '0);
    assign full_s   = (occ_r == OCC_FULL);
    assign push_s   = log_s && (!full_s || pop_s);
    assign drop_s   = log_s && full_s && !pop_s;

    // Next FIFO occupancy/read pointer and the show-ahead head entry that follows this edge.
    always_comb begin
        rd_ptr_s   = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        occ_s      = occ_r;
        head_pc_s  = '0;
        head_cls_s = 4'd0;
        head_exp_s = '0;
        head_act_s = '0;
        case ({push_s, pop_s})
            2'b10:   occ_s = occ_r + OCC_ONE;
            2'b01:   occ_s = occ_r - OCC_ONE;
            default: occ_s = occ_r;
        endcase
        if (occ_s == '0) begin
            head_pc_s = '0;
        end else if (push_s && (rd_ptr_s == wr_ptr_r)) begin
            head_pc_s  = pc;
            head_cls_s = cls_s;
            head_exp_s = expected_s;
            head_act_s = actual_s;
        end else begin
            head_pc_s  = mem_pc_r[rd_ptr_s];
            head_cls_s = mem_cls_r[rd_ptr_s];
            head_exp_s = mem_exp_r[rd_ptr_s];
            head_act_s = mem_act_r[rd_ptr_s];
        end
    end

    // Run/halt state machine with class counters, error counter and first-error capture.
    always_ff @(posedge CLK) begin
        if (!RST || clear) begin
            state_r        <= ST_RUN;
            halted         <= 1'b0;
            err_count      <= '0;
            err_flag       <= 1'b0;
            first_err_pc   <= '0;
            trace_overflow <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (accept_s) begin
                        cnt_r[cls_s] <= sat_inc(cnt_r[cls_s]);
                    end
                    if (log_s) begin
                        err_count <= sat_inc(err_count);
                        if (!err_flag) begin
                            err_flag     <= 1'b1;
                            first_err_pc <= pc;
                        end
                        if (HALT_ON_ERR != 0) begin
                            state_r <= ST_HALTED;
                            halted  <= 1'b1;
                        end
                    end
                end
                ST_HALTED: halted <= 1'b1;
                default: begin
                    state_r <= ST_RUN;
                    halted  <= 1'b0;
                end
            endcase
            if (drop_s) begin
                trace_overflow <= 1'b1;
            end
        end
    end

    // Trace FIFO pointers and registered head outputs.
    always_ff @(posedge CLK) begin
        if (!RST || clear) begin
            rd_ptr_r       <= '0;
            wr_ptr_r       <= '0;
            occ_r          <= '0;
            trace_valid    <= 1'b0;
            trace_pc       <= '0;
            trace_class    <= 4'd0;
            trace_expected <= '0;
            trace_actual   <= '0;
        end else begin
            rd_ptr_r       <= rd_ptr_s;
            wr_ptr_r       <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            occ_r          <= occ_s;
            trace_valid    <= (occ_s != '0);
            trace_pc       <= head_pc_s;
            trace_class    <= head_cls_s;
            trace_expected <= head_exp_s;
            trace_actual   <= head_act_s;
        end
    end

    // Trace storage; contents are meaningless outside the occupied window, so no reset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]  <= pc;
            mem_cls_r[wr_ptr_r] <= cls_s;
            mem_exp_r[wr_ptr_r] <= expected_s;
            mem_act_r[wr_ptr_r] <= actual_s;
        end
    end

    // Flatten the class counters onto the packed output bus.
    always_comb begin
        cnt_class = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            cnt_class[k*CNT_W +: CNT_W] = cnt_r[k];
        end
    end

endmodule

// File: tb/tb_olivia_exec_checker.sv
// Bench for olivia_exec_checker: directed vector table, FIFO/halt/saturation sequences,
// and randomized retires checked against a queue-based reference model.
module tb_olivia_exec_checker;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST, clr0, clr1, valid0, valid1, pop0, pop1, zf;
    logic [31:0] instr;
    logic [63:0] pc, rd1, rd2, imm, alu;

    logic [159:0] cnt0;
    logic [15:0]  err0;
    logic         flag0, halted0, tv0, tovf0;
    logic [63:0]  fpc0, tpc0, texp0, tact0;
    logic [3:0]   tcls0;

    logic [39:0]  cnt1;
    logic [3:0]   err1;
    logic         flag1, halted1, tv1, tovf1;
    logic [63:0]  fpc1, tpc1, texp1, tact1;
    logic [3:0]   tcls1;

    olivia_exec_checker dut0 (
        .CLK(CLK), .RST(RST), .clear(clr0), .valid(valid0), .instr(instr), .pc(pc),
        .rd1(rd1), .rd2(rd2), .imm(imm), .alu_result(alu), .zero_flag(zf),
        .cnt_class(cnt0), .err_count(err0), .err_flag(flag0), .first_err_pc(fpc0),
        .halted(halted0), .trace_valid(tv0), .trace_pc(tpc0), .trace_class(tcls0),
        .trace_expected(texp0), .trace_actual(tact0), .trace_pop(pop0), .trace_overflow(tovf0)
    );

    olivia_exec_checker #(.CNT_W(4), .HALT_ON_ERR(1)) dut1 (
        .CLK(CLK), .RST(RST), .clear(clr1), .valid(valid1), .instr(instr), .pc(pc),
        .rd1(rd1), .rd2(rd2), .imm(imm), .alu_result(alu), .zero_flag(zf),
        .cnt_class(cnt1), .err_count(err1), .err_flag(flag1), .first_err_pc(fpc1),
        .halted(halted1), .trace_valid(tv1), .trace_pc(tpc1), .trace_class(tcls1),
        .trace_expected(texp1), .trace_actual(tact1), .trace_pop(pop1), .trace_overflow(tovf1)
    );

    localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000,
                            OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000,
                            OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000,
                            OP_CBZ = 11'b10110100000, OP_B = 11'b00010100000;
    logic [10:0] ops [8];

    int total = 0;
    int bad = 0;

    // ---------------- reference model ----------------
    typedef struct { logic [63:0] pc; int cls; logic [63:0] e; logic [63:0] a; } ent_t;
    ent_t        q[$];
    int          m_cnt [10];
    int          m_err;
    bit          m_flag, m_ovf;
    logic [63:0] m_fpc;

    function automatic int classify(input logic [31:0] ins);
        if (ins == 32'd0) return 8;
        for (int i = 0; i < 8; i++) if (ins[31:21] == ops[i]) return i;
        return 9;
    endfunction

    task automatic ref_eval(output int c, output logic [63:0] e, output logic [63:0] a, output bit mis);
        c = classify(instr);
        e = 64'd0;
        a = alu;
        case (c)
            0: e = rd1 + rd2;
            1: e = rd1 - rd2;
            2: e = rd1 & rd2;
            3: e = rd1 | rd2;
            4, 5: e = rd1 + imm;
            6: begin e = (rd2 == 64'd0) ? 64'd1 : 64'd0; a = zf ? 64'd1 : 64'd0; end
            9: a = {32'd0, instr};
            default: a = 64'd0;
        endcase
        mis = (c == 9) ? 1'b1 : ((c == 7 || c == 8) ? 1'b0 : (a != e));
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 10; k++) m_cnt[k] = 0;
        m_err = 0; m_flag = 0; m_ovf = 0; m_fpc = 64'd0;
    endtask

    task automatic model_step();
        int c; logic [63:0] e, a; bit mis;
        bit do_pop;
        do_pop = pop0 && (q.size() > 0);
        if (do_pop) q.delete(0);
        if (valid0) begin
            ref_eval(c, e, a, mis);
            if (m_cnt[c] < 65535) m_cnt[c]++;
            if (mis) begin
                if (m_err < 65535) m_err++;
                if (!m_flag) begin m_flag = 1; m_fpc = pc; end
                if (q.size() < 8) q.push_back('{pc, c, e, a});
                else m_ovf = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (!RST || clr0) model_reset();
        else model_step();
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] c0(input int k); return cnt0[k*16 +: 16]; endfunction
    function automatic logic [3:0]  c1(input int k); return cnt1[k*4 +: 4];   endfunction

    task automatic compare_model(input string tag);
        for (int k = 0; k < 10; k++) chk($sformatf("%s_cnt%0d", tag, k), c0(k), m_cnt[k]);
        chk({tag, "_err_count"}, err0, m_err);
        chk({tag, "_err_flag"}, flag0, m_flag);
        chk({tag, "_first_pc"}, fpc0, m_fpc);
        chk({tag, "_halted"}, halted0, 0);
        chk({tag, "_tvalid"}, tv0, q.size() != 0);
        chk({tag, "_tpc"}, tpc0, (q.size() != 0) ? q[0].pc : 64'd0);
        chk({tag, "_tcls"}, tcls0, (q.size() != 0) ? q[0].cls : 0);
        chk({tag, "_texp"}, texp0, (q.size() != 0) ? q[0].e : 64'd0);
        chk({tag, "_tact"}, tact0, (q.size() != 0) ? q[0].a : 64'd0);
        chk({tag, "_tovf"}, tovf0, m_ovf);
    endtask

    function automatic logic [63:0] rand64();
        return ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] instr; logic [63:0] pc, rd1, rd2, imm, alu; logic zf;
        int cls; bit bad; logic [63:0] e, a;
    } vec_t;
    vec_t tab [14];

    function automatic vec_t mk(input logic [31:0] i_, input logic [63:0] p_, r1_, r2_, im_, al_,
                                input logic z_, input int c_, input bit b_, input logic [63:0] e_, a_);
        vec_t v;
        v.instr = i_; v.pc = p_; v.rd1 = r1_; v.rd2 = r2_; v.imm = im_; v.alu = al_; v.zf = z_;
        v.cls = c_; v.bad = b_; v.e = e_; v.a = a_;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int tab_cnt [10];
        int tab_err;
        logic [63:0] tab_fpc;
        int drained;
        int c; logic [63:0] e, a; bit mis;

        ops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, OP_B};
        model_reset();
        tab[0]  = mk({OP_ADD, 21'h00123}, 64'd0, 64'd5, 64'd3, 64'd0, 64'd8, 1'b0, 0, 0, 0, 0);
        tab[1]  = mk({OP_SUB, 21'h00045}, 64'd4, 64'd5, 64'd3, 64'd0, 64'd2, 1'b0, 1, 0, 0, 0);
        tab[2]  = mk({OP_AND, 21'h00000}, 64'd8, 64'd12, 64'd10, 64'd0, 64'd8, 1'b0, 2, 0, 0, 0);
        tab[3]  = mk({OP_ORR, 21'h1FFFF}, 64'd12, 64'd12, 64'd10, 64'd0, 64'd14, 1'b0, 3, 0, 0, 0);
        tab[4]  = mk({OP_LDUR, 21'h00777}, 64'd16, 64'd16, 64'd99, 64'd8, 64'd24, 1'b0, 4, 0, 0, 0);
        tab[5]  = mk({OP_STUR, 21'h00001}, 64'd18, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd96, 1'b0, 5, 0, 0, 0);
        tab[6]  = mk({OP_ADD, 21'h00000}, 64'd20, 64'd7, 64'd1, 64'd0, 64'd9, 1'b0, 0, 1, 64'd8, 64'd9);
        tab[7]  = mk({OP_CBZ, 21'h00010}, 64'd28, 64'd3, 64'd0, 64'd0, 64'd0, 1'b0, 6, 1, 64'd1, 64'd0);
        tab[8]  = mk({OP_CBZ, 21'h00010}, 64'd32, 64'd3, 64'd5, 64'd0, 64'd0, 1'b0, 6, 0, 0, 0);
        tab[9]  = mk({OP_B, 21'h1ABCD}, 64'd36, 64'd1, 64'd2, 64'd0, 64'd77, 1'b1, 7, 0, 0, 0);
        tab[10] = mk(32'd0, 64'd40, 64'd1, 64'd2, 64'd0, 64'd55, 1'b0, 8, 0, 0, 0);
        tab[11] = mk(32'hFFFF_FFFF, 64'd44, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 9, 1, 64'd0, 64'hFFFF_FFFF);
        tab[12] = mk({OP_SUB, 21'h00002}, 64'd48, 64'd0, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 0, 0, 0);
        tab[13] = mk({OP_ADD, 21'h00002}, 64'd52, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd1, 1'b0, 0, 0, 0, 0);

        // reset held two cycles with retires offered
        RST = 1'b0; clr0 = 1'b0; clr1 = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
        valid0 = 1'b1; valid1 = 1'b1; instr = {OP_ADD, 21'd0};
        pc = 64'd4; rd1 = 64'd1; rd2 = 64'd1; imm = 64'd0; alu = 64'd7; zf = 1'b0;
        tick(); tick();
        chk("rst_err_count", err0, 0);
        chk("rst_cnt_add", c0(0), 0);
        chk("rst_err_flag", flag0, 0);
        chk("rst_tvalid", tv0, 0);
        chk("rst_halted1", halted1, 0);
        chk("rst_tvalid1", tv1, 0);
        compare_model("rst");
        RST = 1'b1; valid0 = 1'b0; valid1 = 1'b0;

        for (int k = 0; k < 10; k++) tab_cnt[k] = 0;
        tab_err = 0; tab_fpc = 64'd0;
        for (int i = 0; i < 14; i++) begin
            instr = tab[i].instr; pc = tab[i].pc; rd1 = tab[i].rd1; rd2 = tab[i].rd2;
            imm = tab[i].imm; alu = tab[i].alu; zf = tab[i].zf; valid0 = 1'b1;
            tick();
            tab_cnt[tab[i].cls]++;
            if (tab[i].bad) begin
                tab_err++;
                if (tab_fpc == 64'd0) tab_fpc = tab[i].pc;
            end
            chk($sformatf("tab%0d_cls_count", i), c0(tab[i].cls), tab_cnt[tab[i].cls]);
            chk($sformatf("tab%0d_err_count", i), err0, tab_err);
            chk($sformatf("tab%0d_err_flag", i), flag0, tab_err != 0);
            chk($sformatf("tab%0d_first_pc", i), fpc0, tab_fpc);
            compare_model("tab");
            if (tab[i].bad) begin
                chk($sformatf("tab%0d_tvalid", i), tv0, 1);
                chk($sformatf("tab%0d_tpc", i), tpc0, tab[i].pc);
                chk($sformatf("tab%0d_tcls", i), tcls0, tab[i].cls);
                chk($sformatf("tab%0d_texp", i), texp0, tab[i].e);
                chk($sformatf("tab%0d_tact", i), tact0, tab[i].a);
                valid0 = 1'b0; pop0 = 1'b1;
                tick();
                pop0 = 1'b0;
                chk($sformatf("tab%0d_popped", i), tv0, 0);
                compare_model("tabpop");
            end
        end

        // clear returns everything to the reset state
        valid0 = 1'b0; clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        chk("clr_err_count", err0, 0);
        chk("clr_first_pc", fpc0, 0);
        chk("clr_cnt_add", c0(0), 0);
        compare_model("clr");

        // nine back-to-back mismatches into an 8-deep FIFO
        valid0 = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            instr = {OP_ADD, 21'd5}; pc = 64'(100 + 4 * j); rd1 = 64'(j); rd2 = 64'd1; alu = 64'd0;
            tick();
            compare_model("burst");
            if (j == 8) chk("burst8_overflow", tovf0, 0);
        end
        chk("burst_overflow", tovf0, 1);
        chk("burst_err_count", err0, 9);
        chk("burst_tvalid", tv0, 1);
        chk("burst_head_pc", tpc0, 64'd104);
        // push and pop on a full FIFO
        pc = 64'd200; pop0 = 1'b1;
        tick();
        compare_model("fullpp");
        chk("fullpp_err_count", err0, 10);
        chk("fullpp_head_pc", tpc0, 64'd108);
        valid0 = 1'b0;
        drained = 0;
        for (int n = 0; n < 20; n++) begin
            if (!tv0) break;
            drained++;
            tick();
            compare_model("drain");
        end
        pop0 = 1'b0;
        chk("drain_count", drained, 8);

        // randomized retires against the model
        for (int r = 0; r < 500; r++) begin
            c = $urandom_range(0, 9);
            if (c == 8) instr = 32'd0;
            else if (c == 9) begin
                instr = 32'hFFFF_FFFF;
                for (int t = 0; t < 16; t++) begin
                    instr = $urandom;
                    if (classify(instr) == 9) break;
                end
                if (classify(instr) != 9) instr = 32'hFFFF_FFFF;
            end else instr = {ops[c], 21'($urandom)};
            pc = {$urandom, $urandom}; rd1 = rand64();
            rd2 = ($urandom_range(0, 2) == 0) ? 64'd0 : rand64();
            imm = rand64(); alu = 64'd0; zf = 1'b0;
            ref_eval(c, e, a, mis);
            alu = ($urandom_range(0, 3) != 0) ? e : rand64();
            zf = ($urandom_range(0, 3) != 0) ? (rd2 == 64'd0) : 1'($urandom_range(0, 1));
            valid0 = ($urandom_range(0, 9) != 0);
            pop0 = ($urandom_range(0, 3) == 0);
            clr0 = ($urandom_range(0, 149) == 0);
            tick();
            compare_model("rnd");
        end
        valid0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0;

        // halt-on-error instance: mismatch freezes checking until clear
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        chk("h_clr_halted", halted1, 0);
        instr = {OP_ADD, 21'd0}; pc = 64'd64; rd1 = 64'd5; rd2 = 64'd3; alu = 64'd8; valid1 = 1'b1;
        tick();
        chk("h_add1", c1(0), 1);
        chk("h_not_halted", halted1, 0);
        pc = 64'd68; alu = 64'd9;
        tick();
        chk("h_add2", c1(0), 2);
        chk("h_halted", halted1, 1);
        chk("h_err", err1, 1);
        chk("h_first_pc", fpc1, 64'd68);
        chk("h_tvalid", tv1, 1);
        chk("h_texp", texp1, 64'd8);
        chk("h_tact", tact1, 64'd9);
        alu = 64'd8;
        for (int j = 0; j < 3; j++) begin
            if (j == 2) alu = 64'd1;
            tick();
            chk($sformatf("h_frozen%0d_add", j), c1(0), 2);
            chk($sformatf("h_frozen%0d_err", j), err1, 1);
            chk($sformatf("h_frozen%0d_halted", j), halted1, 1);
        end
        valid1 = 1'b0; pop1 = 1'b1;
        tick();
        pop1 = 1'b0;
        chk("h_pop_tvalid", tv1, 0);
        chk("h_pop_halted", halted1, 1);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        chk("h_clear_halted", halted1, 0);
        chk("h_clear_add", c1(0), 0);
        chk("h_clear_flag", flag1, 0);
        // 4-bit counters saturate at 15
        instr = 32'd0; valid1 = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (j == 14) chk("sat_nop14", c1(8), 14);
            if (j == 15) chk("sat_nop15", c1(8), 15);
        end
        chk("sat_nop20", c1(8), 15);
        chk("sat_no_err", err1, 0);
        valid1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
